// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK/T/D/SR storage bits sharing clock, enable and mode,
// with per-bit change flags, a saturating toggle-event counter and a sticky SR error flag.

module jk_reg_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       d,
    output logic       q,
    output logic       qb,
    output logic       chg,
    output logic       tgl,
    output logic       ill
);
    logic n;

    // tgl/ill are raw per-bit flags for the current inputs; the bank gates them with en
    always_comb begin
        n   = q;
        tgl = 1'b0;
        ill = 1'b0;
        case (mode)
            2'b00: begin
                case ({j, k})
                    2'b01:   n = 1'b0;
                    2'b10:   n = 1'b1;
                    2'b11: begin
                        n   = ~q;
                        tgl = 1'b1;
                    end
                    default: n = q;
                endcase
            end
            2'b01: begin
                if (j) begin
                    n   = ~q;
                    tgl = 1'b1;
                end
            end
            2'b10: n = d;
            default: begin
                case ({j, k})
                    2'b10:   n = 1'b1;
                    2'b01:   n = 1'b0;
                    2'b11:   ill = 1'b1;
                    default: n = q;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= RST_BIT;
            qb  <= ~RST_BIT;
            chg <= 1'b0;
        end else if (en) begin
            q   <= n;
            qb  <= ~n;
            chg <= q ^ n;
        end else begin
            chg <= 1'b0;
        end
    end
endmodule

module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] tgl_cnt,
    output logic             sr_err
);
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] ill;
    logic             tgl_evt;
    logic             ill_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_reg_bit #(.RST_BIT(RESET_VAL[i])) u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .mode  (mode),
            .j     (j[i]),
            .k     (k[i]),
            .d     (d[i]),
            .q     (q[i]),
            .qb    (qb[i]),
            .chg   (chg[i]),
            .tgl   (tgl[i]),
            .ill   (ill[i])
        );
    end

    // One count per edge no matter how many bits toggle
    assign tgl_evt = en & (|tgl);
    assign ill_evt = en & (|ill);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgl_cnt <= '0;
        end else if (tgl_evt && (tgl_cnt != {CNT_W{1'b1}})) begin
            tgl_cnt <= tgl_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_err <= 1'b0;
        end else if (ill_evt) begin
            sr_err <= 1'b1;
        end
    end
endmodule
